// File: rtl/pedestrian_pkg.sv
// Shared types for the pedestrian crossing controller:
// phase encoding and lamp patterns per phase.
package pedestrian_pkg;

  typedef enum logic [2:0] {
    CAR_GREEN,
    CAR_YELLOW,
    ALLRED1,
    PED_GREEN,
    PED_FLASH,
    ALLRED2
  } state_e;

  typedef struct packed {
    logic green;
    logic yellow;
    logic red;
    logic ped_green;
    logic ped_red;
  } lamps_t;

  localparam lamps_t LAMPS_CAR_GREEN = '{
    green: 1'b1, yellow: 1'b0, red: 1'b0,
    ped_green: 1'b0, ped_red: 1'b1
  };
  localparam lamps_t LAMPS_CAR_YELLOW = '{
    green: 1'b0, yellow: 1'b1, red: 1'b0,
    ped_green: 1'b0, ped_red: 1'b1
  };
  localparam lamps_t LAMPS_ALLRED = '{
    green: 1'b0, yellow: 1'b0, red: 1'b1,
    ped_green: 1'b0, ped_red: 1'b1
  };
  localparam lamps_t LAMPS_PED_GREEN = '{
    green: 1'b0, yellow: 1'b0, red: 1'b1,
    ped_green: 1'b1, ped_red: 1'b0
  };
  localparam lamps_t LAMPS_PED_DARK = '{
    green: 1'b0, yellow: 1'b0, red: 1'b1,
    ped_green: 1'b0, ped_red: 1'b0
  };

  // Flash phase blinks ped_green; pedestrian red stays dark.
  function automatic lamps_t lamps_for(
    input state_e s,
    input logic   flash
  );
    lamps_t l;
    unique case (s)
      CAR_GREEN:  l = LAMPS_CAR_GREEN;
      CAR_YELLOW: l = LAMPS_CAR_YELLOW;
      ALLRED1:    l = LAMPS_ALLRED;
      ALLRED2:    l = LAMPS_ALLRED;
      PED_GREEN:  l = LAMPS_PED_GREEN;
      PED_FLASH:  l = flash ? LAMPS_PED_GREEN
                            : LAMPS_PED_DARK;
      default:    l = LAMPS_ALLRED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioning: two-flop synchroniser,
// stability counter, and a one-clock rising-edge pulse.
module button_debounce #(
  parameter int DEBOUNCE_CLKS = 160000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CLKS > 2)
                    ? $clog2(DEBOUNCE_CLKS) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CLKS - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          differ;
  logic          accept;

  assign differ = sync2_q != deb_q;
  assign accept = differ && (cnt_q == CNT_LAST);

  // Accept the new level once it has held long enough.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (accept) begin
      deb_d = sync2_q;
    end else if (differ) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pulse on the clock the debounced level goes high.
  assign rise_o = accept && sync2_q;

  // Synchroniser and debounce state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pedestrian_request.sv
// Demand-driven pedestrian crossing controller:
// prescaler, phase timer, request latch and phase FSM.
module pedestrian_request
  import pedestrian_pkg::*;
#(
  parameter int TIMER_SCALE   = 16000000,
  parameter int T_GREEN_MIN   = 10,
  parameter int T_YELLOW      = 3,
  parameter int T_ALLRED      = 2,
  parameter int T_PED_GREEN   = 6,
  parameter int T_PED_FLASH   = 4,
  parameter int DEBOUNCE_CLKS = 160000
) (
  input  logic pin3_clk_16mhz,
  input  logic reset,
  input  logic pin9_ped_button,
  output logic pin4_green,
  output logic pin5_yellow,
  output logic pin6_red,
  output logic pin7_ped_green,
  output logic pin8_ped_red,
  output logic pin10_wait
);

  localparam int PW = (TIMER_SCALE > 2)
                    ? $clog2(TIMER_SCALE) : 1;
  localparam int M1 = (T_GREEN_MIN > T_YELLOW)
                    ? T_GREEN_MIN : T_YELLOW;
  localparam int M2 = (M1 > T_ALLRED) ? M1 : T_ALLRED;
  localparam int M3 = (M2 > T_PED_GREEN)
                    ? M2 : T_PED_GREEN;
  localparam int TMAX = (M3 > T_PED_FLASH)
                      ? M3 : T_PED_FLASH;
  localparam int TW = $clog2(TMAX + 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          tick;
  state_e        state_q;
  state_e        state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          req_q;
  logic          req_d;
  logic          flash_q;
  logic          flash_d;
  logic          rise;
  logic          req_ok;
  logic          ped_enter;
  lamps_t        lamps;

  button_debounce #(
    .DEBOUNCE_CLKS(DEBOUNCE_CLKS)
  ) u_debounce (
    .clk_i  (pin3_clk_16mhz),
    .rst_i  (reset),
    .btn_i  (pin9_ped_button),
    .rise_o (rise)
  );

  // Prescaler: one tick every TIMER_SCALE clocks.
  always_comb begin
    tick  = pre_q == PW'(TIMER_SCALE - 1);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Phase sequencing and the in-phase tick count.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (tick) begin
      unique case (state_q)
        CAR_GREEN:
          if (req_q &&
              timer_q >= TW'(T_GREEN_MIN - 1))
            state_d = CAR_YELLOW;
        CAR_YELLOW:
          if (timer_q == TW'(T_YELLOW - 1))
            state_d = ALLRED1;
        ALLRED1:
          if (timer_q == TW'(T_ALLRED - 1))
            state_d = PED_GREEN;
        PED_GREEN:
          if (timer_q == TW'(T_PED_GREEN - 1))
            state_d = PED_FLASH;
        PED_FLASH:
          if (timer_q == TW'(T_PED_FLASH - 1))
            state_d = ALLRED2;
        ALLRED2:
          if (timer_q == TW'(T_ALLRED - 1))
            state_d = CAR_GREEN;
        default:
          state_d = CAR_GREEN;
      endcase
      if (state_d != state_q) begin
        timer_d = '0;
      end else if (state_q == CAR_GREEN) begin
        if (timer_q != TW'(T_GREEN_MIN))
          timer_d = timer_q + 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // Request latch; entering PED_GREEN clears it and wins.
  always_comb begin
    req_ok = (state_q == CAR_GREEN)  ||
             (state_q == CAR_YELLOW) ||
             (state_q == ALLRED1)    ||
             (state_q == ALLRED2);
    ped_enter = (state_d == PED_GREEN) &&
                (state_q != PED_GREEN);
    req_d = req_q;
    if (rise && req_ok)
      req_d = 1'b1;
    if (ped_enter)
      req_d = 1'b0;
    flash_d = ~timer_d[0];
  end

  // All state registers.
  always_ff @(posedge pin3_clk_16mhz) begin
    if (reset) begin
      pre_q   <= '0;
      state_q <= CAR_GREEN;
      timer_q <= '0;
      req_q   <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      flash_q <= flash_d;
    end
  end

  assign lamps          = lamps_for(state_q, flash_q);
  assign pin4_green     = lamps.green;
  assign pin5_yellow    = lamps.yellow;
  assign pin6_red       = lamps.red;
  assign pin7_ped_green = lamps.ped_green;
  assign pin8_ped_red   = lamps.ped_red;
  assign pin10_wait     = req_q;

endmodule

// File: tb/tb_pedestrian_request.sv
// Randomised scoreboard bench for pedestrian_request
// against a phase-table reference model.
module tb_pedestrian_request;

  localparam int TG  = 4;
  localparam int TY  = 2;
  localparam int TA  = 1;
  localparam int TPG = 3;
  localparam int TPF = 4;
  localparam int DB  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic g, y, r, pg, pr, w;

  always #5 clk = ~clk;

  pedestrian_request #(
    .TIMER_SCALE   (1),
    .T_GREEN_MIN   (TG),
    .T_YELLOW      (TY),
    .T_ALLRED      (TA),
    .T_PED_GREEN   (TPG),
    .T_PED_FLASH   (TPF),
    .DEBOUNCE_CLKS (DB)
  ) dut (
    .pin3_clk_16mhz  (clk),
    .reset           (rst),
    .pin9_ped_button (btn),
    .pin4_green      (g),
    .pin5_yellow     (y),
    .pin6_red        (r),
    .pin7_ped_green  (pg),
    .pin8_ped_red    (pr),
    .pin10_wait      (w)
  );

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  // Phases 0..5: green, yellow, allred, pedgreen,
  // flash, allred. Durations in clocks.
  int dur[6] = '{TG, TY, TA, TPG, TPF, TA};
  int m_p, m_n, m_run;
  bit m_req, m_s1, m_s2, m_deb;

  function automatic logic [5:0] expect_out();
    logic [4:0] l;
    case (m_p)
      0:       l = 5'b10001;
      1:       l = 5'b01001;
      3:       l = 5'b00110;
      4:       l = (m_n % 2 == 0) ? 5'b00110
                                  : 5'b00100;
      default: l = 5'b00101;
    endcase
    return {l, m_req};
  endfunction

  task automatic model_step(input bit b, input bit rs);
    bit rise, adv, nreq;
    if (rs) begin
      m_p = 0; m_n = 0; m_run = 0;
      m_req = 0; m_s1 = 0; m_s2 = 0; m_deb = 0;
    end else begin
      rise = 0;
      if (m_s2 != m_deb) begin
        m_run++;
        if (m_run == DB) begin
          m_deb = m_s2;
          m_run = 0;
          rise = m_deb;
        end
      end else begin
        m_run = 0;
      end
      if (m_p == 0) adv = m_req && (m_n + 1 >= TG);
      else          adv = (m_n + 1 == dur[m_p]);
      nreq = m_req ||
        (rise && (m_p inside {0, 1, 2, 5}));
      if (adv) begin
        m_p = (m_p + 1) % 6;
        m_n = 0;
        if (m_p == 3) nreq = 0;
      end else begin
        m_n++;
      end
      m_req = nreq;
      m_s2 = m_s1;
      m_s1 = b;
    end
    exp_q.push_back(expect_out());
  endtask

  task automatic cyc(input bit b, input bit rs);
    @(negedge clk);
    btn = b;
    rst = rs;
    model_step(b, rs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0);
  endtask

  task automatic press(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0);
  endtask

  task automatic wait_phase(input int p, input int n,
                            input string tag);
    int k;
    k = 0;
    while (!(m_p == p && m_n == n) && k < 200) begin
      cyc(0, 0);
      k++;
    end
    if (k >= 200) begin
      errors++;
      $display("FAIL %s: timeout waiting phase %0d/%0d",
               tag, p, n);
    end
  endtask

  // Monitor: pop one expectation per clock and check
  // safety invariants on the same sample.
  initial begin
    logic [5:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {g, y, r, pg, pr, w};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL lamps @%0t: got %b want %b",
                   $time, a, e);
        end
        checks++;
        if (!$onehot({g, y, r})) begin
          errors++;
          $display("FAIL car_onehot @%0t: got %b%b%b",
                   $time, g, y, r);
        end
        checks++;
        if (pg && pr) begin
          errors++;
          $display("FAIL ped_both @%0t: got 11 want !11",
                   $time);
        end
        checks++;
        if (pg && !r) begin
          errors++;
          $display("FAIL pg_without_red @%0t", $time);
        end
      end
    end
  end

  initial begin
    int len;
    bit val;
    cyc(0, 1);
    cyc(0, 1);
    // Idle: green rests.
    idle(100);
    // Single-clock glitch is filtered.
    cyc(1, 0);
    idle(20);
    // Held press from 20 clocks after reset.
    cyc(0, 1);
    idle(20);
    press(10);
    idle(40);
    // Press right after reset: minimum green holds.
    cyc(0, 1);
    press(6);
    idle(40);
    // Press during PED_GREEN is ignored.
    press(4);
    wait_phase(3, 0, "reach_pg");
    press(4);
    idle(60);
    // Press landing in ALLRED2 is served again.
    press(4);
    wait_phase(4, 1, "reach_pf");
    press(4);
    idle(40);
    // Reset in PED_FLASH.
    press(4);
    wait_phase(4, 1, "reach_pf2");
    cyc(0, 1);
    idle(10);
    // Random button activity with rare resets.
    for (int i = 0; i < 150; i++) begin
      val = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++)
        cyc(val, $urandom_range(0, 299) == 0);
    end
    idle(30);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pedestrian_request.md
Name: pedestrian_request

Overview:
- Next-generation pedestrian crossing controller: demand-driven, not free-running.
- Car traffic rests on green until a debounced push-button request is latched and a minimum green time has elapsed.
- It then sequences yellow, all-red, pedestrian green, flashing pedestrian green and all-red back to car green.
- All phase durations are parameters. Top-level block driving the board LED pins.

Parameters:
TIMER_SCALE, 16000000, clocks per timer tick (16000000 = 1 s at 16 MHz; 1 in simulation)
T_GREEN_MIN, 10, minimum car-green ticks before a request is served (>=1)
T_YELLOW, 3, car-yellow ticks (>=1)
T_ALLRED, 2, all-red ticks, used both before and after the pedestrian phase (>=1)
T_PED_GREEN, 6, steady pedestrian-green ticks (>=1)
T_PED_FLASH, 4, flashing pedestrian-green ticks (>=1)
DEBOUNCE_CLKS, 160000, clocks the synchronised button must differ from its debounced value before the change is accepted (>=2)

Ports:
pin3_clk_16mhz  in  1  system clock, 16 MHz
reset  in  1  synchronous, active-high reset
pin9_ped_button  in  1  asynchronous push-button, active high
pin4_green  out  1  car green
pin5_yellow  out  1  car yellow
pin6_red  out  1  car red
pin7_ped_green  out  1  pedestrian green
pin8_ped_red  out  1  pedestrian red
pin10_wait  out  1  "request registered" lamp

Behaviour:
- One clock: pin3_clk_16mhz. Reset is synchronous and active-high; it clears every register.
- Reset output values: green=1, yellow=0, red=0, ped_green=0, ped_red=1, wait=0. State after reset is CAR_GREEN.
- Prescaler: counts 0..TIMER_SCALE-1. Emits a one-clock tick when the count is TIMER_SCALE-1, then wraps to 0. With TIMER_SCALE=1, tick is high every clock.
- Button input path:
  - Two-flop synchroniser.
  - Debouncer: counter increments while the synchronised value differs from the debounced value; resets to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CLKS-1 while the values still differ, the debounced value takes the synchronised value.
  - A debounced rising edge sets the request latch.
  - A glitch shorter than DEBOUNCE_CLKS clocks never sets the request latch.
- Request latch:
  - Set on a debounced rising edge in CAR_GREEN, CAR_YELLOW, ALLRED1 or ALLRED2.
  - Debounced edges during PED_GREEN and PED_FLASH are ignored.
  - Cleared on the clock the FSM enters PED_GREEN.
  - If set and clear coincide, clear wins.
  - pin10_wait equals the request latch.
- Phase timer: counts ticks within the current state and resets to 0 on every state change. In CAR_GREEN it saturates at T_GREEN_MIN.
- FSM states and transitions; all transitions are taken on a tick clock only:
  - CAR_GREEN -> CAR_YELLOW: when the request is set and T_GREEN_MIN ticks have elapsed in CAR_GREEN. The request may arrive before or after the minimum.
  - CAR_YELLOW -> ALLRED1: after T_YELLOW ticks.
  - ALLRED1 -> PED_GREEN: after T_ALLRED ticks.
  - PED_GREEN -> PED_FLASH: after T_PED_GREEN ticks.
  - PED_FLASH -> ALLRED2: after T_PED_FLASH ticks.
  - ALLRED2 -> CAR_GREEN: after T_ALLRED ticks.
  - Each timed state lasts exactly T×TIMER_SCALE clocks.
- Output decode: outputs are registered, driven from the state register and a flash flop. There is no combinational path from any input.
  - CAR_GREEN: green.
  - CAR_YELLOW: yellow.
  - ALLRED1, ALLRED2: red plus ped_red.
  - PED_GREEN: red plus ped_green.
  - PED_FLASH: red; ped_green on during even-numbered ticks of the phase (0, 2, ...) and off during odd ticks; ped_red=0.
  - All non-pedestrian states (CAR_GREEN, CAR_YELLOW, ALLRED1, ALLRED2) drive ped_red=1.
- Safety invariants, checked every clock:
  - Exactly one car lamp is on.
  - ped_green and ped_red are never both on.
  - ped_green=1 implies red=1.
- Reset mid-cycle, from any state: the next clock is CAR_GREEN with reset outputs; request, debouncer, prescaler and timer are all cleared.
- Button held continuously produces one request only. A new request requires a debounced release followed by a debounced press.

Decomposition:
- Shared package `pedestrian_pkg`: state enum, and the lamp-pattern constants per state.
- One natural sub-module: `button_debounce`, containing the synchroniser, DEBOUNCE_CLKS counter and rising-edge pulse output.
- Prescaler, phase timer and FSM stay in pedestrian_request.

Test Plan:
(All with TIMER_SCALE=1, T_GREEN_MIN=4, T_YELLOW=2, T_ALLRED=1, T_PED_GREEN=3, T_PED_FLASH=4, DEBOUNCE_CLKS=2.)
1. Reset, no button for 100 clocks -> green=1, ped_red=1, wait=0 throughout.
2. Button high for 1 clock -> wait stays 0 and FSM stays in CAR_GREEN.
3. Button held 10 clocks, starting 20 clocks after reset -> wait=1 within 5 clocks. Then, on consecutive ticks: yellow ×2, all-red ×1, red+ped_green ×3, flash ped_green 1,0,1,0, all-red ×1, green. Wait clears when PED_GREEN is entered.
4. Press latched 1 clock after reset -> CAR_YELLOW not entered before tick 4 of CAR_GREEN, then the full sequence from scenario 3.
5. Press during PED_GREEN -> ignored; after return, green stays on indefinitely. A press during ALLRED2 -> served again, with CAR_GREEN lasting exactly 4 ticks.
6. Reset asserted in PED_FLASH -> next clock green=1, ped_red=1, ped_green=0, wait=0. Safety invariants hold every clock across all scenarios.
